// File: rtl/add_array_arbiter_pkg.sv
// Shared constants and state encoding for the add-array arbiter.
package add_array_arbiter_pkg;
    localparam int NCH_DEF = 3;
    localparam int W_DEF   = 8;
    localparam int TAG_W   = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;
endpackage

// File: rtl/add_array_arbiter_if.sv
// Requester operand channels plus the single output token port.
interface add_array_arbiter_if
    import add_array_arbiter_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) ();
    logic [NCH-1:0][W-1:0] a_data;
    logic [NCH-1:0][W-1:0] b_data;
    logic [NCH-1:0]        a_send;
    logic [NCH-1:0]        b_send;
    logic [NCH-1:0]        a_ack;
    logic [NCH-1:0]        b_ack;
    logic [W-1:0]          out_data;
    logic [TAG_W-1:0]      out_tag;
    logic                  out_send;
    logic                  out_rdy;
    logic                  out_ack;
    logic [15:0]           out_count;
    logic [15:0]           grant_count;

    modport master (
        output a_data, b_data, a_send, b_send, out_rdy, out_ack,
        input  a_ack, b_ack, out_data, out_tag, out_send, out_count, grant_count
    );

    modport slave (
        input  a_data, b_data, a_send, b_send, out_rdy, out_ack,
        output a_ack, b_ack, out_data, out_tag, out_send, out_count, grant_count
    );
endinterface

// File: rtl/add_array_rr_pick.sv
// Rotating-priority search: first eligible channel strictly after ptr, wrapping.
module add_array_rr_pick
    import add_array_arbiter_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0]   eligible_i,
    input  logic [TAG_W-1:0] ptr_i,
    output logic [TAG_W-1:0] grant_o,
    output logic             any_o
);
    logic [NCH-1:0][TAG_W-1:0] cand_idx;
    logic [NCH-1:0]            cand_ok;

    // Candidate gi sits at offset gi+1 from ptr; ptr < NCH so one subtract wraps it.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
        logic [TAG_W:0] sum_w;
        assign sum_w = {1'b0, ptr_i} + (TAG_W+1)'(gi + 1);
        assign cand_idx[gi] = (sum_w >= (TAG_W+1)'(NCH)) ? TAG_W'(sum_w - (TAG_W+1)'(NCH))
                                                          : TAG_W'(sum_w);
        assign cand_ok[gi] = eligible_i[cand_idx[gi]];
    end

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand_ok[i]) begin
                grant_o = cand_idx[i];
                any_o   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/add_array_arbiter.sv
// Round-robin arbiter feeding a shared adder into a one-entry output register.
module add_array_arbiter
    import add_array_arbiter_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    add_array_arbiter_if.slave bus
);
    state_e           state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic [15:0]      gcnt_q, gcnt_d;

    logic [NCH-1:0]   eligible;
    logic [TAG_W-1:0] grant;
    logic             any_grant;
    logic             valid;
    logic             issue;
    logic             transfer;
    logic [W-1:0]     sel_sum;
    logic             unused_out_ack;

    assign unused_out_ack = bus.out_ack;
    assign eligible       = bus.a_send & bus.b_send;

    add_array_rr_pick #(.NCH(NCH)) u_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .any_o      (any_grant)
    );

    assign valid    = (state_q == FULL);
    assign transfer = valid && bus.out_rdy;
    // Gated by RESET so no operand is consumed while the register is being cleared.
    assign issue    = any_grant && (!valid || bus.out_rdy) && !RESET;

    always_comb begin
        sel_sum = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant == TAG_W'(k)) begin
                sel_sum = bus.a_data[k] + bus.b_data[k];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = issue ? FULL : EMPTY;
            FULL:    state_d = (transfer && !issue) ? EMPTY : FULL;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        ptr_d  = ptr_q;
        gcnt_d = gcnt_q;
        if (issue) begin
            data_d = sel_sum;
            tag_d  = grant;
            ptr_d  = grant;
            gcnt_d = gcnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            data_q <= '0;
            tag_q  <= '0;
            ptr_q  <= TAG_W'(NCH - 1);
            gcnt_q <= '0;
        end else begin
            data_q <= data_d;
            tag_q  <= tag_d;
            ptr_q  <= ptr_d;
            gcnt_q <= gcnt_d;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ack
        assign bus.a_ack[gi] = issue && (grant == TAG_W'(gi));
        assign bus.b_ack[gi] = issue && (grant == TAG_W'(gi));
    end

    always_comb begin
        bus.out_send    = transfer;
        bus.out_data    = data_q;
        bus.out_tag     = tag_q;
        bus.out_count   = 16'h0001;
        bus.grant_count = gcnt_q;
    end
endmodule

// File: tb/tb_add_array_arbiter.sv
// Directed and random stimulus checked against a token-level model of the arbiter.
module tb_add_array_arbiter;
    localparam int NCH = 3;
    localparam int W   = 8;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    add_array_arbiter_if #(.NCH(NCH), .W(W)) bus ();

    add_array_arbiter #(.NCH(NCH), .W(W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: held token (valid/data/tag), last granted channel, issue count.
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_tag;
    int           m_ptr;
    logic [15:0]  m_cnt;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_tag   = 0;
        m_ptr   = NCH - 1;
        m_cnt   = 16'd0;
    endtask

    task automatic check_reset_state();
        check("rst_send",  32'(bus.out_send), 32'(0));
        check("rst_gcnt",  32'(bus.grant_count), 32'(0));
        check("rst_data",  32'(bus.out_data), 32'(0));
        check("rst_tag",   32'(bus.out_tag), 32'(0));
        check("rst_a_ack", 32'(bus.a_ack), 32'(0));
        check("rst_b_ack", 32'(bus.b_ack), 32'(0));
    endtask

    task automatic drive(int k, bit as, bit bs, logic [W-1:0] ad, logic [W-1:0] bd);
        bus.a_send[k] = as;
        bus.b_send[k] = bs;
        bus.a_data[k] = ad;
        bus.b_data[k] = bd;
    endtask

    task automatic idle();
        for (int k = 0; k < NCH; k++) drive(k, 1'b0, 1'b0, '0, '0);
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, then advances the model.
    task automatic cycle();
        int           g;
        bit           issue;
        bit           xfer;
        logic [NCH-1:0] exp_ack;
        logic [W-1:0] sum;
        #3;
        g = -1;
        if (!RESET) begin
            for (int j = NCH; j >= 1; j--) begin
                int k;
                k = (m_ptr + j) % NCH;
                if (bus.a_send[k] && bus.b_send[k]) g = k;
            end
        end
        issue   = (g >= 0) && (!m_valid || bus.out_rdy);
        xfer    = m_valid && bus.out_rdy;
        exp_ack = '0;
        sum     = '0;
        if (issue) begin
            exp_ack[g] = 1'b1;
            sum = bus.a_data[g] + bus.b_data[g];
            $display("t=%0t issue ch%0d a=%0h b=%0h sum=%0h", $time, g,
                     bus.a_data[g], bus.b_data[g], sum);
        end
        if (xfer) $display("t=%0t transfer data=%0h tag=%0d", $time, m_data, m_tag);
        check("a_ack",     32'(bus.a_ack), 32'(exp_ack));
        check("b_ack",     32'(bus.b_ack), 32'(exp_ack));
        check("out_send",  32'(bus.out_send), 32'(xfer));
        check("gcnt",      32'(bus.grant_count), 32'(m_cnt));
        check("out_count", 32'(bus.out_count), 32'(1));
        if (m_valid) begin
            check("out_data", 32'(bus.out_data), 32'(m_data));
            check("out_tag",  32'(bus.out_tag), 32'(m_tag));
        end
        @(posedge CLK);
        if (RESET) begin
            model_reset();
        end else if (issue) begin
            m_valid = 1'b1;
            m_data  = sum;
            m_tag   = g;
            m_ptr   = g;
            m_cnt   = m_cnt + 16'd1;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        RESET       = 1'b1;
        bus.out_rdy = 1'b0;
        bus.out_ack = 1'b0;
        idle();
        @(posedge CLK);
        #1;
        model_reset();
        check_reset_state();
        cycle();
        RESET = 1'b0;

        // Single eligible channel: 5 + 3 arrives one cycle after the ACK.
        bus.out_rdy = 1'b1;
        drive(0, 1'b1, 1'b1, 8'h05, 8'h03);
        cycle();
        idle();
        #2;
        check("sum_0503", 32'(bus.out_data), 32'h08);
        check("send_0503", 32'(bus.out_send), 32'(1));
        #(-0);
        cycle();

        // All channels eligible, consumer always ready: grants rotate.
        for (int n = 0; n < 7; n++) begin
            for (int k = 0; k < NCH; k++) drive(k, 1'b1, 1'b1, W'($urandom), W'($urandom));
            cycle();
        end
        idle();
        cycle();

        // Stall with C1 eligible, then release.
        bus.out_rdy = 1'b0;
        drive(1, 1'b1, 1'b1, 8'h11, 8'h22);
        for (int n = 0; n < 4; n++) cycle();
        bus.out_rdy = 1'b1;
        cycle();
        idle();
        cycle();

        // Wrapping sum.
        drive(2, 1'b1, 1'b1, 8'hFF, 8'h02);
        cycle();
        idle();
        #2;
        check("sum_wrap", 32'(bus.out_data), 32'h01);
        cycle();

        // Lone A send is never acknowledged.
        drive(2, 1'b1, 1'b0, 8'h33, 8'h44);
        for (int n = 0; n < 10; n++) begin
            bus.out_ack = 1'($urandom);
            cycle();
        end
        idle();

        // Reset while a token is held and stalled.
        bus.out_rdy = 1'b0;
        drive(1, 1'b1, 1'b1, 8'h07, 8'h09);
        cycle();
        for (int k = 0; k < NCH; k++) drive(k, 1'b1, 1'b1, W'($urandom), W'($urandom));
        cycle();
        RESET = 1'b1;
        #1;
        model_reset();
        check_reset_state();
        bus.out_rdy = 1'b1;
        cycle();
        bus.out_rdy = 1'b0;
        RESET = 1'b0;
        #2;
        check("first_grant", 32'(bus.a_ack), 32'h1);
        cycle();
        bus.out_rdy = 1'b1;
        cycle();

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < NCH; k++) begin
                drive(k, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      W'($urandom), W'($urandom));
            end
            bus.out_rdy = $urandom_range(0, 2) != 0;
            bus.out_ack = 1'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
